// File: rtl/sqrt_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_unit_param
// Purpose  : Fixed-point square root by radix-2 restoring digit recurrence.
//            Leading all-zero digit pairs are skipped, so the iteration count
//            depends on the operand magnitude. Reports the truncated-root
//            remainder, an exact flag and a negative-input flag.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_unit_param #(
  parameter  int IN_W   = 36,
  parameter  int FRAC_W = 28,
  parameter  int EXT    = 0,
  localparam int RW     = IN_W - 1 + 2 * EXT,
  localparam int QW     = (RW + 1) / 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IN_W-1:0] data_e,
  input  logic            sqrt_unit_start,
  input  logic            round_en,
  output logic            busy,
  output logic            sqrt_unit_done,
  output logic [QW-1:0]   data_out_f,
  output logic [QW:0]     remainder,
  output logic            exact,
  output logic            err_neg
);

  localparam int DW = 2 * QW;          // radicand zero-extended to whole pairs
  localparam int CW = $clog2(QW + 1);  // iteration counter width
  localparam int LW = $clog2(DW + 1);  // leading-zero count width
  localparam int TW = QW + 4;          // {rem, pair} trial width incl. sign

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   rad;        // radicand, next pair to consume sits at the top
  logic            neg_in;     // captured sign bit
  logic            rnd;        // captured round_en
  logic [QW-1:0]   root;       // partial root
  logic [QW+1:0]   rem;        // partial remainder
  logic [CW-1:0]   cnt;        // iterations left

  logic [DW-1:0]   rad_in;
  logic [LW-1:0]   lz;
  logic [CW-1:0]   n_iter;
  logic [TW-1:0]   acc;
  logic [TW-1:0]   sub;
  logic [TW-1:0]   trial;
  logic            trial_neg;
  logic [QW+1:0]   rem_next;
  logic            round_up;
  logic [QW-1:0]   q_final;
  logic            unused_bits;

  // An odd fraction width would leave the result with a half-bit binary point.
  if (FRAC_W % 2 != 0) begin : g_frac_check
    $error("sqrt_unit_param: FRAC_W must be even");
  end

  // Magnitude scaled by the extra result fraction bits, zero-extended to DW.
  assign rad_in = DW'(data_e[IN_W-2:0]) << (2 * EXT);

  // Leading-zero count of the captured radicand (highest set bit wins).
  always_comb begin
    lz = LW'(DW);
    for (int i = 0; i < DW; i++) begin
      if (rad[i]) lz = LW'(DW - 1 - i);
    end
  end

  // Pairs that remain after dropping the all-zero leading ones.
  assign n_iter = (neg_in || rad == '0) ? '0 : CW'(QW - int'(lz >> 1));

  // One restoring step: bring down a pair and try to subtract {root, 01}.
  assign acc       = {rem, rad[DW-1 -: 2]};
  assign sub       = {2'b00, root, 2'b01};
  assign trial     = acc - sub;
  assign trial_neg = trial[TW-1];
  assign rem_next  = trial_neg ? acc[QW+1:0] : trial[QW+1:0];
  // The remainder never exceeds twice the root, so these upper bits stay zero.
  assign unused_bits = ^{acc[TW-1:QW+2], trial[TW-2:QW+2]};

  // Round-to-nearest bumps the root when the remainder passes the midpoint;
  // an all-ones root cannot grow and is left saturated.
  assign round_up = rnd && (rem[QW:0] > {1'b0, root}) && !(&root);
  assign q_final  = root + QW'(round_up);

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rad            <= '0;
      neg_in         <= 1'b0;
      rnd            <= 1'b0;
      root           <= '0;
      rem            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      sqrt_unit_done <= 1'b0;
      data_out_f     <= '0;
      remainder      <= '0;
      exact          <= 1'b0;
      err_neg        <= 1'b0;
    end else begin
      sqrt_unit_done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the done-pulse cycle; a start seen
          // then is dropped and the unit frees up on the following edge.
          if (busy) begin
            busy <= 1'b0;
          end else if (sqrt_unit_start) begin
            rad    <= rad_in;
            neg_in <= data_e[IN_W-1];
            rnd    <= round_en;
            busy   <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          // Skipped pairs are all zero, so root and remainder start at zero.
          rad   <= rad << (2 * (QW - int'(n_iter)));
          root  <= '0;
          rem   <= '0;
          cnt   <= n_iter;
          state <= (n_iter == '0) ? DONE : ITER;
        end
        ITER: begin
          rad  <= rad << 2;
          root <= {root[QW-2:0], ~trial_neg};
          rem  <= rem_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (neg_in) begin
            data_out_f <= '0;
            remainder  <= '0;
            exact      <= 1'b0;
            err_neg    <= 1'b1;
          end else begin
            data_out_f <= q_final;
            remainder  <= rem[QW:0];
            exact      <= (rem == '0);
            err_neg    <= 1'b0;
          end
          sqrt_unit_done <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_unit_param
// Purpose  : Self-checking bench for sqrt_unit_param: directed corner cases
//            plus randomized operands against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_unit_param;

  localparam int IN_W = 36;
  localparam int FRAC_W = 28;
  localparam int EXT = 0;
  localparam int QW = 18;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [IN_W-1:0] data_e;
  logic            sqrt_unit_start;
  logic            round_en;
  logic            busy;
  logic            sqrt_unit_done;
  logic [QW-1:0]   data_out_f;
  logic [QW:0]     remainder;
  logic            exact;
  logic            err_neg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sqrt_unit_param #(
    .IN_W  (IN_W),
    .FRAC_W(FRAC_W),
    .EXT   (EXT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_e         (data_e),
    .sqrt_unit_start(sqrt_unit_start),
    .round_en       (round_en),
    .busy           (busy),
    .sqrt_unit_done (sqrt_unit_done),
    .data_out_f     (data_out_f),
    .remainder      (remainder),
    .exact          (exact),
    .err_neg        (err_neg)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  function automatic int bitlen(input longint v);
    int b = 0;
    while (v > 0) begin
      b++;
      v = v >> 1;
    end
    return b;
  endfunction

  // Integer square root by bisection on squares.
  function automatic longint isqrt(input longint r);
    longint lo = 0;
    longint hi = longint'(1) << QW;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // Reference: expected result, remainder, flags and iteration count.
  task automatic model(input logic [IN_W-1:0] d, input logic rnd,
                       output longint q, output longint rem,
                       output longint ex, output longint en, output int n);
    longint r;
    r = longint'(d[IN_W-2:0]) << (2 * EXT);
    if (d[IN_W-1]) begin
      q = 0; rem = 0; ex = 0; en = 1; n = 0;
    end else begin
      q   = isqrt(r);
      rem = r - q * q;
      ex  = (rem == 0) ? 1 : 0;
      en  = 0;
      n   = (r == 0) ? 0 : QW - (2 * QW - bitlen(r)) / 2;
      if (rnd && rem > q && q != (longint'(1) << QW) - 1) q = q + 1;
    end
  endtask

  // Waits (bounded) for the done pulse; lat counts edges after the start edge.
  task automatic wait_done(output int lat, output bit got, output bit busy_ok);
    lat = 0; got = 1'b0; busy_ok = busy;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (sqrt_unit_done) got = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [IN_W-1:0] d,
                        input logic rnd, input bit hammer);
    longint q, rem, ex, en;
    int n, lat, extra;
    bit got, bok;
    model(d, rnd, q, rem, ex, en, n);
    @(negedge clk);
    data_e = d; round_en = rnd; sqrt_unit_start = 1'b1;
    @(posedge clk); #1;
    if (!hammer) begin
      sqrt_unit_start = 1'b0;
      data_e   = IN_W'({$urandom(), $urandom()});
      round_en = ~rnd;
    end
    wait_done(lat, got, bok);
    sqrt_unit_start = 1'b0;
    check({name, " done_seen"}, longint'(got), 1);
    check({name, " latency"}, longint'(lat), longint'(n + 2));
    check({name, " busy_held"}, longint'(bok), 1);
    check({name, " q"}, longint'(data_out_f), q);
    check({name, " rem"}, longint'(remainder), rem);
    check({name, " exact"}, longint'(exact), ex);
    check({name, " err_neg"}, longint'(err_neg), en);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (sqrt_unit_done) extra++;
    end
    check({name, " extra_done"}, longint'(extra), 0);
    check({name, " idle_busy"}, longint'(busy), 0);
    check({name, " q_held"}, longint'(data_out_f), q);
  endtask

  initial begin
    int lat;
    bit got, bok;
    int extra;
    logic [IN_W-1:0] d;
    logic [IN_W-2:0] mag;
    longint qq;

    reset_n = 1'b0; sqrt_unit_start = 1'b0; data_e = '0; round_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", longint'(busy), 0);
    check("rst done", longint'(sqrt_unit_done), 0);
    check("rst q", longint'(data_out_f), 0);
    check("rst rem", longint'(remainder), 0);
    check("rst flags", longint'({exact, err_neg}), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst busy", longint'(busy), 0);

    // Directed cases
    run_op("t1_four",     36'h0_4000_0000, 1'b0, 1'b0);
    run_op("t2_three_tr", 36'h0_3000_0000, 1'b0, 1'b0);
    run_op("t2_three_rn", 36'h0_3000_0000, 1'b1, 1'b0);
    run_op("t3_max_rn",   36'h7_FFFF_FFFF, 1'b1, 1'b0);
    run_op("t4_zero",     36'h0_0000_0000, 1'b0, 1'b0);
    run_op("t4_neg",      36'h8_0000_0010, 1'b1, 1'b0);
    run_op("one_lsb",     36'h0_0000_0001, 1'b1, 1'b0);
    run_op("t5_hammer",   36'h0_4000_0000, 1'b0, 1'b1);

    // Start raised in the done cycle is ignored, then accepted a cycle later.
    @(negedge clk);
    data_e = '0; round_en = 1'b0; sqrt_unit_start = 1'b1;
    @(posedge clk); #1;
    sqrt_unit_start = 1'b0;
    wait_done(lat, got, bok);
    check("dstart zero_done", longint'(got), 1);
    check("dstart zero_lat", longint'(lat), 2);
    sqrt_unit_start = 1'b1; data_e = 36'h0_4000_0000;
    @(posedge clk); #1;
    check("dstart ignored", longint'(busy), 0);
    @(posedge clk); #1;
    check("dstart accepted", longint'(busy), 1);
    sqrt_unit_start = 1'b0;
    wait_done(lat, got, bok);
    check("dstart t1_lat", longint'(lat), 18);
    check("dstart t1_q", longint'(data_out_f), 'h08000);
    repeat (2) @(posedge clk);

    // Reset in the middle of an iteration
    run_op("t6_pre", 36'h7_FFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    data_e = 36'h7_FFFF_FFFF; round_en = 1'b1; sqrt_unit_start = 1'b1;
    @(posedge clk); #1;
    sqrt_unit_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6 busy", longint'(busy), 0);
    check("t6 done", longint'(sqrt_unit_done), 0);
    check("t6 q", longint'(data_out_f), 0);
    check("t6 rem", longint'(remainder), 0);
    check("t6 flags", longint'({exact, err_neg}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (sqrt_unit_done || busy) extra++;
    end
    check("t6 no_activity", longint'(extra), 0);
    run_op("t6_after", 36'h0_4000_0000, 1'b0, 1'b0);

    // Randomized operands: varied magnitudes, perfect squares, some negatives
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        qq  = longint'($urandom_range(0, 185363));
        mag = (IN_W-1)'(qq * qq);
      end else begin
        mag = (IN_W-1)'({$urandom(), $urandom()}) >> $urandom_range(0, 34);
      end
      d = {($urandom_range(0, 7) == 0), mag};
      run_op($sformatf("rand%0d", i), d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
